// File: rtl/ofm_collector_pkg.sv
// ofm_collector_pkg
//   Shared constants and types for the OFM collector: PE lane count,
//   lane/word/address widths, FIFO entry width and the control FSM states.
package ofm_collector_pkg;

    localparam int unsigned NUM_PE  = 16;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned ENTRY_W = NUM_PE * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ofm_fifo.sv
// ofm_fifo
//   Synchronous FIFO holding whole PE-array pixels (one entry per pixel).
//   A push into a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   push, din   - write request and entry data
//   pop         - remove head entry (ignored when empty)
//   dout        - head entry (combinational read)
//   full, empty - occupancy status
module ofm_fifo
    import ofm_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ofm_collector.sv
// ofm_collector
//   Collects one OFM layer from the PE array: each all-lanes-valid cycle is
//   buffered as one pixel, then serialized into four 32-bit words with
//   sequential word addresses.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   start, num_pixels    - layer start pulse and pixel count (sampled in IDLE)
//   valid, ofm_lane      - per-PE valid flags and activated bytes
//   out_data, out_addr   - packed word and its word address
//   out_valid, out_ready - word handshake
//   busy, done           - layer in progress / one-cycle completion pulse
//   overflow, lane_err   - sticky errors, cleared by an accepted start
module ofm_collector #(
    parameter int unsigned NUM_PE     = ofm_collector_pkg::NUM_PE,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIX_W      = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [PIX_W-1:0]                             num_pixels,
    input  logic [NUM_PE-1:0]                            valid,
    input  logic [NUM_PE*ofm_collector_pkg::LANE_W-1:0]  ofm_lane,
    output logic [ofm_collector_pkg::WORD_W-1:0]         out_data,
    output logic [ofm_collector_pkg::ADDR_W-1:0]         out_addr,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overflow,
    output logic                                         lane_err
);

    import ofm_collector_pkg::*;

    localparam int unsigned ENT_W  = NUM_PE * LANE_W;
    localparam int unsigned BPW    = WORD_W / LANE_W;
    localparam int unsigned WORDS  = ENT_W / WORD_W;
    localparam int unsigned WSEL_W = $clog2(WORDS);

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0]    num_pix_q, num_pix_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WSEL_W-1:0]   word_q, word_d;
    logic                overflow_q, overflow_d;
    logic                lane_err_q, lane_err_d;

    logic                start_ok, capture_req, lane_bad;
    logic                push, pop, xfer;
    logic                fifo_full, fifo_empty;
    logic [ENT_W-1:0]    head;

    ofm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ofm_lane),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Datapath: capture, serializer and counters
    always_comb begin
        start_ok    = (state_q == ST_IDLE) && start;
        capture_req = (state_q == ST_RUN) && (&valid);
        lane_bad    = (state_q == ST_RUN) && (valid != '0) && !(&valid);
        out_valid   = !fifo_empty;
        xfer        = out_valid && out_ready;
        pop         = xfer && (word_q == WSEL_W'(WORDS - 1));
        // A full FIFO still takes the capture if the head leaves this cycle.
        push        = capture_req && (!fifo_full || pop);

        pix_cnt_d  = pix_cnt_q;
        num_pix_d  = num_pix_q;
        addr_d     = addr_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        lane_err_d = lane_err_q;

        if (xfer) begin
            addr_d = addr_q + 1'b1;
            word_d = word_q + 1'b1;
        end

        if (start_ok) begin
            pix_cnt_d  = '0;
            num_pix_d  = num_pixels;
            addr_d     = '0;
            overflow_d = 1'b0;
            lane_err_d = 1'b0;
        end else begin
            // Dropped pixels still count so the layer terminates.
            if (capture_req) pix_cnt_d = pix_cnt_q + 1'b1;
            if (capture_req && !push) overflow_d = 1'b1;
            if (lane_bad) lane_err_d = 1'b1;
        end

        // Lane 4k of the selected word lands in the top byte.
        out_data = '0;
        if (!fifo_empty) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                out_data[WORD_W-1-LANE_W*b -: LANE_W] =
                    head[(32'(word_q) * BPW + b) * LANE_W +: LANE_W];
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = (num_pixels == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (capture_req && (pix_cnt_d == num_pix_q)) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done     = (state_q == ST_DONE);
        out_addr = addr_q;
        overflow = overflow_q;
        lane_err = lane_err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            num_pix_q  <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            lane_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            num_pix_q  <= num_pix_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
            lane_err_q <= lane_err_d;
        end
    end

endmodule

// File: tb/tb_ofm_collector.sv
module tb_ofm_collector;

    logic         clk;
    logic         reset;
    logic         start;
    logic [15:0]  num_pixels;
    logic [15:0]  valid;
    logic [127:0] ofm_lane;
    logic [31:0]  out_data;
    logic [19:0]  out_addr;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         lane_err;

    int unsigned checks;
    int unsigned failures;

    ofm_collector #(
        .NUM_PE     (16),
        .FIFO_DEPTH (4),
        .PIX_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_pixels (num_pixels),
        .valid      (valid),
        .ofm_lane   (ofm_lane),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .lane_err   (lane_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word made of four consecutive byte values starting at b.
    function automatic logic [31:0] exp_word(input int unsigned b);
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    // Pixel p carries byte 16*p+n on lane n.
    task automatic set_lanes(input int unsigned p);
        for (int unsigned n = 0; n < 16; n++) ofm_lane[8*n +: 8] = 8'(16 * p + n);
    endtask

    // Expect n consecutive words from address 0; word w of the stream starts at byte 4*(w+woff).
    task automatic expect_words(input int unsigned n, input int unsigned woff);
        for (int unsigned w = 0; w < n; w++) begin
            chk($sformatf("out_valid[%0d]", w), 32'(out_valid), 32'd1);
            chk($sformatf("out_data[%0d]", w), out_data, exp_word(4 * (w + woff)));
            chk($sformatf("out_addr[%0d]", w), 32'(out_addr), 32'(w));
            tick();
            valid = '0;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        start      = 1'b0;
        num_pixels = '0;
        valid      = '0;
        ofm_lane   = '0;
        out_ready  = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_lane_err", 32'(lane_err), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        reset = 1'b1;
        tick();

        // Two pixels streamed with out_ready high
        out_ready  = 1'b1;
        num_pixels = 16'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_idle_valid", 32'(out_valid), 32'd0);
        valid = '1;
        set_lanes(0);
        tick();
        set_lanes(1);
        expect_words(8, 0);
        chk("a_empty", 32'(out_valid), 32'd0);
        chk("a_addr_end", 32'(out_addr), 32'd8);
        chk("a_no_early_done", 32'(done), 32'd0);
        tick();
        chk("a_done", 32'(done), 32'd1);
        chk("a_busy_done", 32'(busy), 32'd0);
        tick();
        chk("a_done_pulse", 32'(done), 32'd0);

        // Backpressure: out_ready low for 10 cycles
        out_ready  = 1'b0;
        num_pixels = 16'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        valid = '1;
        set_lanes(4);
        tick();
        valid = '0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("b_hold_valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("b_hold_data[%0d]", i), out_data, 32'h40414243);
            chk($sformatf("b_hold_addr[%0d]", i), 32'(out_addr), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        expect_words(4, 16);
        chk("b_empty", 32'(out_valid), 32'd0);
        tick();
        chk("b_done", 32'(done), 32'd1);
        tick();

        // Overflow: six captures into a 4-deep FIFO with no draining
        out_ready  = 1'b0;
        num_pixels = 16'd6;
        start      = 1'b1;
        tick();
        start = 1'b0;
        valid = '1;
        for (int unsigned p = 0; p < 6; p++) begin
            set_lanes(p);
            tick();
            chk($sformatf("c_overflow_after_%0d", p + 1), 32'(overflow), (p >= 4) ? 32'd1 : 32'd0);
        end
        valid = '0;
        chk("c_drain_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        expect_words(16, 0);
        chk("c_empty", 32'(out_valid), 32'd0);
        chk("c_overflow_sticky", 32'(overflow), 32'd1);
        tick();
        chk("c_done", 32'(done), 32'd1);
        tick();

        // Zero-pixel layer: done one cycle after start, clears overflow
        num_pixels = 16'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_overflow_clr", 32'(overflow), 32'd0);
        chk("z_out_valid", 32'(out_valid), 32'd0);
        chk("z_busy", 32'(busy), 32'd0);
        tick();
        chk("z_done_pulse", 32'(done), 32'd0);
        chk("z_out_valid2", 32'(out_valid), 32'd0);

        // Partial valid: no capture, lane_err, pixel count unchanged
        out_ready  = 1'b1;
        num_pixels = 16'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        valid = 16'h00FF;
        set_lanes(0);
        tick();
        chk("d_lane_err", 32'(lane_err), 32'd1);
        chk("d_no_capture", 32'(out_valid), 32'd0);
        chk("d_busy", 32'(busy), 32'd1);
        valid = '1;
        tick();
        set_lanes(1);
        expect_words(8, 0);
        chk("d_addr_end", 32'(out_addr), 32'd8);
        tick();
        chk("d_done", 32'(done), 32'd1);
        chk("d_lane_err_sticky", 32'(lane_err), 32'd1);
        tick();

        // Reset during DRAIN
        out_ready  = 1'b0;
        num_pixels = 16'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("e_lane_err_clr", 32'(lane_err), 32'd0);
        valid = '1;
        set_lanes(2);
        tick();
        valid = '0;
        chk("e_pending", 32'(out_valid), 32'd1);
        chk("e_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("e_async_valid", 32'(out_valid), 32'd0);
        chk("e_async_busy", 32'(busy), 32'd0);
        chk("e_async_data", out_data, 32'd0);
        tick();
        chk("e_rst_valid", 32'(out_valid), 32'd0);
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_done", 32'(done), 32'd0);
        chk("e_rst_data", out_data, 32'd0);
        chk("e_rst_addr", 32'(out_addr), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("e_no_done[%0d]", i), 32'(done), 32'd0);
            chk($sformatf("e_idle_valid[%0d]", i), 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
